// File: rtl/fir_pkg.sv
// Shared definitions for the filter library: width helpers and the
// default signed sample/coefficient/accumulator types.
package fir_pkg;

  localparam int DEF_D_W  = 8;
  localparam int DEF_C_W  = 8;
  localparam int DEF_TAPS = 4;

  // Ceiling log2, with clog2(1) = 0. Used for address and growth widths.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Full-precision output width of a TAPS-term signed sum of products.
  function automatic int out_width(input int d_w, input int c_w, input int taps);
    return d_w + c_w + clog2(taps);
  endfunction

  localparam int DEF_O_W = out_width(DEF_D_W, DEF_C_W, DEF_TAPS);

  typedef logic signed [DEF_D_W-1:0] sample_t;
  typedef logic signed [DEF_C_W-1:0] coef_t;
  typedef logic signed [DEF_O_W-1:0] acc_t;

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x C_W coefficient register file. One write port, all entries read
// in parallel. The read-out forwards a write happening in the same cycle
// so the product stage sees a coefficient on the very edge it is written.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int C_W  = 8,
  parameter int TAPS = 4,
  parameter int A_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [A_W-1:0]        addr,
  input  logic [C_W-1:0]        wdata,
  output logic [TAPS*C_W-1:0]   coef_flat
);

  logic [C_W-1:0] bank [TAPS];

  // Store writes; an address with no matching entry (>= TAPS) touches nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) bank[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (addr == A_W'(k)) bank[k] <= wdata;
      end
    end
  end

  // Parallel read-out with same-cycle write forwarding.
  always_comb begin
    coef_flat = '0;
    for (int k = 0; k < TAPS; k++) begin
      coef_flat[k*C_W +: C_W] = (we && addr == A_W'(k)) ? wdata : bank[k];
    end
  end

endmodule

// File: rtl/fir_ntaps_prog.sv
// Direct-form FIR with programmable coefficients, valid-qualified input,
// a registered product stage and a registered adder stage (latency 2).
module fir_ntaps_prog
  import fir_pkg::*;
#(
  parameter  int D_W  = 8,
  parameter  int C_W  = 8,
  parameter  int TAPS = 4,
  localparam int A_W  = clog2(TAPS),
  localparam int O_W  = out_width(D_W, C_W, TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  coef_we,
  input  logic [A_W-1:0]        coef_addr,
  input  logic signed [C_W-1:0] coef_data,
  input  logic                  in_valid,
  input  logic signed [D_W-1:0] x,
  output logic                  out_valid,
  output logic signed [O_W-1:0] y
);

  localparam int P_W = D_W + C_W;

  logic [TAPS*C_W-1:0]   coef_flat;
  logic signed [C_W-1:0] coef [TAPS];
  logic signed [D_W-1:0] tap  [TAPS];
  logic signed [P_W-1:0] prod [TAPS];
  logic signed [O_W-1:0] sum;
  logic                  v0;
  logic                  v1;

  fir_coef_bank #(
    .C_W  (C_W),
    .TAPS (TAPS),
    .A_W  (A_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (coef_we),
    .addr      (coef_addr),
    .wdata     (coef_data),
    .coef_flat (coef_flat)
  );

  // Unpack the flat coefficient bus into signed per-tap values.
  always_comb begin
    for (int k = 0; k < TAPS; k++) coef[k] = coef_flat[k*C_W +: C_W];
  end

  // Delay line advances only on valid samples; clr empties the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) tap[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) tap[k] <= '0;
    end else if (in_valid) begin
      tap[0] <= x;
      for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
    end
  end

  // First valid stage: marks that the delay line holds a fresh sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      v0 <= 1'b0;
    else if (clr) v0 <= 1'b0;
    else          v0 <= in_valid;
  end

  // Product stage: full-precision signed tap x coefficient products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      v1 <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        for (int k = 0; k < TAPS; k++) prod[k] <= P_W'(tap[k]) * P_W'(coef[k]);
      end
    end
  end

  // Adder tree over sign-extended products; O_W leaves room for every sum.
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + O_W'(prod[k]);
  end

  // Output stage: y only changes on valid results and holds across gaps and clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) y <= sum;
    end
  end

endmodule

// File: tb/tb_fir_ntaps_prog.sv
// Scoreboard bench for fir_ntaps_prog: directed vectors push hand-computed
// results; monitors pop and compare whenever out_valid is seen.
module tb_fir_ntaps_prog;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clr = 1'b0;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_addr = '0;
  logic signed [7:0]  coef_data = '0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  x = '0;
  logic               out_valid;
  logic signed [17:0] y;

  logic               coef_we5 = 1'b0;
  logic [2:0]         coef_addr5 = '0;
  logic               in_valid5 = 1'b0;
  logic               out_valid5;
  logic signed [18:0] y5;

  int checks   = 0;
  int failures = 0;
  int expq[$];
  int expq5[$];
  int last_exp = 0;
  int mon_e;
  int mon_e5;

  always #5 clk = ~clk;

  fir_ntaps_prog #(.D_W(8), .C_W(8), .TAPS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y         (y)
  );

  fir_ntaps_prog #(.D_W(8), .C_W(8), .TAPS(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .coef_we   (coef_we5),
    .coef_addr (coef_addr5),
    .coef_data (coef_data),
    .in_valid  (in_valid5),
    .x         (x),
    .out_valid (out_valid5),
    .y         (y5)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic writeCoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 8'(d);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic writeCoef5(input int a, input int d);
    coef_we5   = 1'b1;
    coef_addr5 = 3'(a);
    coef_data  = 8'(d);
    tick();
    coef_we5   = 1'b0;
  endtask

  task automatic applyStimulus(input bit v, input int xv, input int e);
    in_valid = v;
    x        = 8'(xv);
    if (v) expq.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Main monitor: value check on out_valid, hold check on every other cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected out_valid", longint'(out_valid), 0);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("y", longint'(y), longint'(mon_e));
          last_exp = mon_e;
        end
      end else begin
        checkOutput("y hold", longint'(y), longint'(last_exp));
      end
    end
  end

  // Monitor for the 5-tap instance.
  always @(negedge clk) begin
    if (!rst && out_valid5) begin
      if (expq5.size() == 0) begin
        checkOutput("unexpected out_valid5", longint'(out_valid5), 0);
      end else begin
        mon_e5 = expq5.pop_front();
        checkOutput("y5", longint'(y5), longint'(mon_e5));
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("reset y", longint'(y), 0);
    checkOutput("reset out_valid", longint'(out_valid), 0);
    idle(2);
    rst = 1'b0;
    tick();

    $display("[TB] impulse");
    writeCoef(0, -1); writeCoef(1, 4); writeCoef(2, 4); writeCoef(3, -1);
    applyStimulus(1, 1, -1);
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, -1);
    applyStimulus(1, 0, 0);
    idle(3);

    $display("[TB] extremes");
    pulseClr();
    for (int k = 0; k < 4; k++) writeCoef(k, -128);
    applyStimulus(1, -128, 16384);
    applyStimulus(1, -128, 32768);
    applyStimulus(1, -128, 49152);
    applyStimulus(1, -128, 65536);
    applyStimulus(1, -128, 65536);
    idle(3);
    for (int k = 0; k < 4; k++) writeCoef(k, 127);
    for (int i = 0; i < 4; i++) applyStimulus(1, -128, -65024);
    idle(3);

    $display("[TB] gapped stream");
    pulseClr();
    writeCoef(0, 1); writeCoef(1, 2); writeCoef(2, 3); writeCoef(3, 4);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 9, 0);
    applyStimulus(0, 9, 0);
    applyStimulus(1, 2, 4);
    applyStimulus(1, 3, 10);
    idle(3);

    $display("[TB] live reprogram");
    pulseClr();
    for (int k = 0; k < 4; k++) writeCoef(k, 1);
    applyStimulus(1, 10, 10);
    applyStimulus(1, 10, 20);
    applyStimulus(1, 10, 30);
    applyStimulus(1, 10, 40);
    applyStimulus(1, 10, 80);
    writeCoef(2, 5);
    applyStimulus(1, 10, 80);
    tick();
    writeCoef(2, 1);
    applyStimulus(1, 10, 40);
    idle(3);

    $display("[TB] clr behaviour");
    writeCoef(0, -1); writeCoef(1, 4); writeCoef(2, 4); writeCoef(3, -1);
    in_valid = 1'b1; x = 8'sd5;
    tick();
    in_valid = 1'b0;
    pulseClr();
    clr = 1'b1; in_valid = 1'b1; x = 8'sd7;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    applyStimulus(1, 1, -1);
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, -1);
    idle(3);

    $display("[TB] reset mid-stream");
    in_valid = 1'b1; x = 8'sd3;
    tick();
    tick();
    rst = 1'b1;
    expq.delete();
    last_exp = 0;
    #1;
    checkOutput("mid reset y", longint'(y), 0);
    checkOutput("mid reset out_valid", longint'(out_valid), 0);
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(3);
    applyStimulus(1, 50, 0);
    applyStimulus(1, -7, 0);
    applyStimulus(1, 100, 0);
    idle(3);

    $display("[TB] address guard on 5-tap instance");
    for (int k = 0; k < 5; k++) writeCoef5(k, 1);
    writeCoef5(5, 100);
    writeCoef5(6, 100);
    writeCoef5(7, 100);
    for (int i = 1; i <= 5; i++) begin
      in_valid5 = 1'b1;
      x = 8'sd10;
      expq5.push_back(10 * i);
      tick();
    end
    in_valid5 = 1'b0;
    idle(4);

    checkOutput("pending results", longint'(expq.size()), 0);
    checkOutput("pending results5", longint'(expq5.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
